time_sequencer: RTL and testbench

TIME_SEQUENCER -- requirements
Module: time_sequencer

---
 rtl/time_sequencer.sv | 158 +++++++++++++++
 tb/tb_time_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_sequencer.sv
// Clock-setting sequencer: one-second prescaler, button sync/edge detect, RUN/SET_HR/SET_MIN FSM
// and per-digit increment/wrap strobes derived from the current digit values.
module time_sequencer #(
  parameter int TICK_DIV   = 32768,
  parameter int HOLD_TICKS = 1
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        mode_btn,
  input  logic        adv_btn,
  input  logic [23:0] digits,
  output logic [5:0]  inc,
  output logic [5:0]  zero,
  output logic [1:0]  mode,
  output logic        sec_pulse
);

  localparam int PW       = $clog2(TICK_DIV);
  localparam int RPT_PER  = TICK_DIV / 4;
  localparam int HOLD_CYC = HOLD_TICKS * TICK_DIV;
  localparam int RW       = $clog2(HOLD_CYC + RPT_PER + 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  logic          r_rst_n;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_mode_sync, r_adv_sync;
  logic          r_mode_prev, r_adv_prev;
  logic          r_mode_ev, r_adv_ev;
  logic          r_rpt_arm;
  logic [RW-1:0] r_rpt_cnt;
  state_t        r_mode;
  logic          r_stb_run, r_stb_hr, r_stb_min, r_stb_clr;

  logic w_tick, w_rpt, w_adv_ev;
  logic w_m0, w_m1, w_m2, w_m3, w_h23, w_z4, w_z5;

  // Assertion is immediate; release takes effect one edge later so the count starts clean.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) r_rst_n <= 1'b0;
    else          r_rst_n <= 1'b1;
  end

  always_ff @(posedge clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_mode_sync <= '0;
      r_adv_sync  <= '0;
      r_mode_prev <= 1'b0;
      r_adv_prev  <= 1'b0;
      r_mode_ev   <= 1'b0;
      r_adv_ev    <= 1'b0;
    end else begin
      r_mode_sync <= {r_mode_sync[0], mode_btn};
      r_adv_sync  <= {r_adv_sync[0], adv_btn};
      r_mode_prev <= r_mode_sync[1];
      r_adv_prev  <= r_adv_sync[1];
      r_mode_ev   <= r_mode_sync[1] & ~r_mode_prev;
      r_adv_ev    <= r_adv_sync[1] & ~r_adv_prev;
    end
  end

  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  // The counter sits at HOLD_CYC once per repeat period after the initial hold has elapsed.
  assign w_rpt    = r_rpt_arm & r_adv_sync[1] & (r_rpt_cnt == RW'(HOLD_CYC));
  assign w_adv_ev = r_adv_ev | w_rpt;

  always_ff @(posedge clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_presc   <= '0;
      sec_pulse <= 1'b0;
      r_mode    <= RUN;
      r_stb_run <= 1'b0;
      r_stb_hr  <= 1'b0;
      r_stb_min <= 1'b0;
      r_stb_clr <= 1'b0;
      r_rpt_arm <= 1'b0;
      r_rpt_cnt <= '0;
    end else begin
      r_stb_hr  <= 1'b0;
      r_stb_min <= 1'b0;
      r_stb_clr <= 1'b0;
      sec_pulse <= w_tick;
      r_stb_run <= w_tick && (r_mode == RUN);
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;

      if (!r_adv_sync[1]) r_rpt_arm <= 1'b0;
      if (r_rpt_arm)
        r_rpt_cnt <= (r_rpt_cnt == RW'(HOLD_CYC + RPT_PER - 1)) ? RW'(HOLD_CYC)
                                                                 : r_rpt_cnt + 1'b1;

      if (r_mode_ev) begin
        r_rpt_arm <= 1'b0;
        case (r_mode)
          RUN:     r_mode <= SET_HR;
          SET_HR:  r_mode <= SET_MIN;
          default: begin
            r_mode    <= RUN;
            r_stb_clr <= 1'b1;
            r_presc   <= '0;
          end
        endcase
      end else if (w_adv_ev && (r_mode != RUN)) begin
        if (r_mode == SET_HR) r_stb_hr  <= 1'b1;
        else                  r_stb_min <= 1'b1;
        if (r_adv_ev) begin
          r_rpt_arm <= 1'b1;
          r_rpt_cnt <= RW'(1);
        end
      end
    end
  end

  assign mode = r_mode;

  // Out-of-range digit values are treated as already at their maximum.
  assign w_m0  = digits[3:0]   >= 4'd9;
  assign w_m1  = digits[7:4]   >= 4'd5;
  assign w_m2  = digits[11:8]  >= 4'd9;
  assign w_m3  = digits[15:12] >= 4'd5;
  assign w_h23 = (digits[23:20] >= 4'd2) && (digits[19:16] >= 4'd3);
  assign w_z4  = (digits[19:16] >= 4'd9) || w_h23;
  assign w_z5  = w_h23 || (digits[23:20] >= 4'd2);

  always_comb begin
    inc  = '0;
    zero = '0;
    if (r_stb_run) begin
      inc[0] = 1'b1;
      inc[1] = w_m0;
      inc[2] = w_m0 & w_m1;
      inc[3] = w_m0 & w_m1 & w_m2;
      inc[4] = w_m0 & w_m1 & w_m2 & w_m3;
      inc[5] = w_m0 & w_m1 & w_m2 & w_m3 & w_z4;
      zero   = {w_z5, w_z4, w_m3, w_m2, w_m1, w_m0} & inc;
    end
    if (r_stb_hr) begin
      inc[4]  = 1'b1;
      inc[5]  = w_z4;
      zero[4] = w_z4;
      zero[5] = w_z4 & w_z5;
    end
    if (r_stb_min) begin
      inc[2]  = 1'b1;
      inc[3]  = w_m2;
      zero[2] = w_m2;
      zero[3] = w_m2 & w_m3;
    end
    if (r_stb_clr) begin
      inc[1:0]  = 2'b11;
      zero[1:0] = 2'b11;
    end
  end

endmodule

// File: tb/tb_time_sequencer.sv
// Directed bench for time_sequencer with TICK_DIV=8, HOLD_TICKS=1.
module tb_time_sequencer;

  logic        clock;
  logic        n_reset;
  logic        mode_btn;
  logic        adv_btn;
  logic [23:0] digits;
  logic [5:0]  inc;
  logic [5:0]  zero;
  logic [1:0]  mode;
  logic        sec_pulse;

  int checks = 0;
  int errors = 0;

  time_sequencer #(.TICK_DIV(8), .HOLD_TICKS(1)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .mode_btn  (mode_btn),
    .adv_btn   (adv_btn),
    .digits    (digits),
    .inc       (inc),
    .zero      (zero),
    .mode      (mode),
    .sec_pulse (sec_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    n_reset = 1'b0; mode_btn = 1'b0; adv_btn = 1'b0; digits = 24'h123409;
    #2;
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got %b want 00", mode); end
    checks++; if (inc !== 6'b0) begin errors++; $display("FAIL reset_inc got %b want 000000", inc); end
    checks++; if (zero !== 6'b0) begin errors++; $display("FAIL reset_zero got %b want 000000", zero); end
    checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL reset_sec got %b want 0", sec_pulse); end
    cycles(3);
  endtask

  task automatic test_first_tick;
    @(negedge clock) n_reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (c == 8) begin
        checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL first_tick_early got %b want 0", sec_pulse); end
      end
      if (c == 9) begin
        checks++; if (sec_pulse !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", sec_pulse); end
        checks++; if (inc !== 6'b000011) begin errors++; $display("FAIL run_123409_inc got %b want 000011", inc); end
        checks++; if (zero !== 6'b000001) begin errors++; $display("FAIL run_123409_zero got %b want 000001", zero); end
      end
      if (c == 10) begin
        checks++; if ({inc, zero} !== 12'b0) begin errors++; $display("FAIL run_idle got inc %b zero %b want 0", inc, zero); end
      end
    end
  endtask

  task automatic test_run_patterns;
    logic [23:0] dv [3];
    logic [5:0]  iv [3];
    logic [5:0]  zv [3];
    bit          seen;
    dv = '{24'h235959, 24'h195959, 24'h093958};
    iv = '{6'b111111, 6'b111111, 6'b000001};
    zv = '{6'b111111, 6'b011111, 6'b000000};
    for (int p = 0; p < 3; p++) begin
      digits = dv[p];
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(posedge clock); #1;
        if (sec_pulse === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL run_pulse_%0d got none want pulse within 12 cycles", p); end
      checks++; if (inc !== iv[p]) begin errors++; $display("FAIL run_inc_%0d got %b want %b", p, inc, iv[p]); end
      checks++; if (zero !== zv[p]) begin errors++; $display("FAIL run_zero_%0d got %b want %b", p, zero, zv[p]); end
      cycles(1);
      checks++; if (inc !== 6'b0) begin errors++; $display("FAIL run_one_cycle_%0d got %b want 000000", p, inc); end
    end
  endtask

  task automatic test_run_ignores_adv;
    int stray;
    stray = 0;
    digits = 24'h120000;
    @(negedge clock) adv_btn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (c == 12) adv_btn = 1'b0;
      if (inc !== 6'b0 && sec_pulse !== 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL run_adv_ignored got %0d strobes want 0", stray); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL run_adv_mode got %b want 00", mode); end
  endtask

  task automatic test_mode_press(input logic [1:0] want);
    int at;
    at = 0;
    @(negedge clock) mode_btn = 1'b1;
    for (int c = 1; c <= 8 && at == 0; c++) begin
      @(posedge clock); #1;
      if (mode === want) at = c;
    end
    mode_btn = 1'b0;
    checks++; if (at != 4) begin errors++; $display("FAIL mode_to_%b got cycle %0d want 4", want, at); end
    cycles(5);
  endtask

  task automatic test_adv_table(input string nm, input logic [23:0] dv[3],
                                input logic [5:0] iv[3], input logic [5:0] zv[3], input int n);
    int at;
    for (int p = 0; p < n; p++) begin
      digits = dv[p];
      at = 0;
      @(negedge clock) adv_btn = 1'b1;
      for (int c = 1; c <= 8 && at == 0; c++) begin
        @(posedge clock); #1;
        if (inc !== 6'b0) at = c;
      end
      adv_btn = 1'b0;
      checks++; if (at != 4) begin errors++; $display("FAIL %s_latency_%0d got cycle %0d want 4", nm, p, at); end
      checks++; if (inc !== iv[p]) begin errors++; $display("FAIL %s_inc_%0d got %b want %b", nm, p, inc, iv[p]); end
      checks++; if (zero !== zv[p]) begin errors++; $display("FAIL %s_zero_%0d got %b want %b", nm, p, zero, zv[p]); end
      cycles(1);
      checks++; if ({inc, zero} !== 12'b0) begin errors++; $display("FAIL %s_one_cycle_%0d got inc %b zero %b want 0", nm, p, inc, zero); end
      cycles(5);
    end
  endtask

  task automatic test_set_hr;
    logic [23:0] dv [3];
    logic [5:0]  iv [3];
    logic [5:0]  zv [3];
    dv = '{24'h231234, 24'h091234, 24'h141234};
    iv = '{6'b110000, 6'b110000, 6'b010000};
    zv = '{6'b110000, 6'b010000, 6'b000000};
    test_adv_table("set_hr", dv, iv, zv, 3);
  endtask

  task automatic test_set_min;
    logic [23:0] dv [3];
    logic [5:0]  iv [3];
    logic [5:0]  zv [3];
    dv = '{24'h125934, 24'h124734, 24'h125959};
    iv = '{6'b001100, 6'b000100, 6'b001100};
    zv = '{6'b001100, 6'b000000, 6'b001100};
    test_adv_table("set_min", dv, iv, zv, 3);
  endtask

  task automatic test_auto_repeat;
    int strobes[$];
    int bad_val, bad_gap, pulses;
    bad_val = 0; bad_gap = 0; pulses = 0;
    digits = 24'h120034;
    @(negedge clock) adv_btn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (inc !== 6'b0) begin
        strobes.push_back(c);
        if (inc !== 6'b000100 || zero !== 6'b000000) bad_val++;
      end
      if (sec_pulse === 1'b1) pulses++;
      if (c == 24) adv_btn = 1'b0;
    end
    checks++; if (strobes.size() != 9) begin errors++; $display("FAIL repeat_count got %0d want 9", strobes.size()); end
    else begin
      checks++; if (strobes[0] != 4) begin errors++; $display("FAIL repeat_first got cycle %0d want 4", strobes[0]); end
      checks++; if (strobes[1] != 12) begin errors++; $display("FAIL repeat_start got cycle %0d want 12", strobes[1]); end
      for (int k = 2; k < 9; k++) if (strobes[k] - strobes[k-1] != 2) bad_gap++;
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL repeat_period got %0d bad gaps want 0", bad_gap); end
      checks++; if (strobes[8] != 26) begin errors++; $display("FAIL repeat_stop got last cycle %0d want 26", strobes[8]); end
    end
    checks++; if (bad_val != 0) begin errors++; $display("FAIL repeat_value got %0d bad strobes want 0", bad_val); end
    checks++; if (pulses != 5) begin errors++; $display("FAIL set_sec_pulse got %0d pulses want 5", pulses); end
    cycles(5);
  endtask

  task automatic test_mode_adv_same;
    int nstb, at, hi;
    logic [5:0] si, sz;
    nstb = 0; at = 0; hi = 0; si = '0; sz = '0;
    digits = 24'h125959;
    @(negedge clock) begin mode_btn = 1'b1; adv_btn = 1'b1; end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); #1;
      if (c == 5) begin mode_btn = 1'b0; adv_btn = 1'b0; end
      if (c <= 11 && inc !== 6'b0) begin
        nstb++;
        if (at == 0) begin at = c; si = inc; sz = zero; end
        if (inc[3:2] !== 2'b00) hi++;
      end
      if (c == 4) begin
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL same_mode got %b want 00", mode); end
      end
      if (c == 11) begin
        checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL clr_presc_early got %b want 0", sec_pulse); end
      end
      if (c == 12) begin
        checks++; if (sec_pulse !== 1'b1) begin errors++; $display("FAIL clr_presc_tick got %b want 1", sec_pulse); end
      end
    end
    checks++; if (nstb != 1 || at != 4) begin errors++; $display("FAIL clr_strobe got %0d strobes at %0d want 1 at 4", nstb, at); end
    checks++; if (si !== 6'b000011 || sz !== 6'b000011) begin errors++; $display("FAIL clr_value got inc %b zero %b want 000011 000011", si, sz); end
    checks++; if (hi != 0) begin errors++; $display("FAIL clr_no_minute got %0d minute strobes want 0", hi); end
    cycles(5);
  endtask

  task automatic test_reset_mid_strobe;
    bit seen;
    seen = 1'b0;
    digits = 24'h231234;
    @(negedge clock) adv_btn = 1'b1;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(posedge clock); #1;
      if (inc !== 6'b0) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_strobe_seen got none want strobe"); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if ({inc, zero} !== 12'b0) begin errors++; $display("FAIL async_rst_out got inc %b zero %b want 0", inc, zero); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL async_rst_mode got %b want 00", mode); end
    checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL async_rst_sec got %b want 0", sec_pulse); end
    adv_btn = 1'b0;
    cycles(2);
    @(negedge clock) n_reset = 1'b1;
    cycles(4);
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL post_rst_mode got %b want 00", mode); end
  endtask

  initial begin
    test_reset;
    test_first_tick;
    test_run_patterns;
    test_run_ignores_adv;
    test_mode_press(2'b01);
    test_set_hr;
    test_mode_press(2'b10);
    test_set_min;
    test_auto_repeat;
    test_mode_adv_same;
    test_mode_press(2'b01);
    test_reset_mid_strobe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
